// File: rtl/stream_demux4_pkg.sv
// Shared types and constants for the 4-way stream demultiplexer.
// Channel select, slot state and statistics counter width live here.
package stream_demux4_pkg;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    typedef logic [1:0] ch_sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_t sel);
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice: 1-cycle load-to-valid, data held while stalled.
// Load and drain on the same edge keeps the slot FULL with the new word.
module demux_slot
    import stream_demux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_t state_q;
    slot_state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = FULL;
        end else if (state_q == FULL && ready) begin
            state_d = EMPTY;
        end
    end

    // Payload only moves on load, so it stays stable under stall and after drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    assign valid = (state_q == FULL);

endmodule

// File: rtl/stream_demux4.sv
// Routes one input stream to 4 one-entry channel slots; 1-cycle latency, a stalled
// channel only blocks words addressed to it. STREAM_DEMUX4_STATS_EN adds drain counters.
module stream_demux4
    import stream_demux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  ch_sel_t                 in_sel,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data
`ifdef STREAM_DEMUX4_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] out_count
`endif
);

    logic              accept;
    logic [NUM_CH-1:0] load;

    // A FULL slot can still take a word when it drains on the same edge.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;
    assign load     = sel_onehot(in_sel) & {NUM_CH{accept}};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*WIDTH +: WIDTH])
        );
    end

`ifdef STREAM_DEMUX4_STATS_EN
    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (out_valid[k] && out_ready[k] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign out_count[k*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Directed and random stimulus against a per-channel queue scoreboard for stream_demux4.
module tb_stream_demux4;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [1:0]             in_sel;
    logic [NCH-1:0]         out_valid;
    logic [NCH-1:0]         out_ready;
    logic [NCH*WIDTH-1:0]   out_data;
`ifdef STREAM_DEMUX4_STATS_EN
    logic [NCH*8-1:0]       out_count;
`endif

    stream_demux4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef STREAM_DEMUX4_STATS_EN
        ,
        .out_count (out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] q [NCH][$];
    int               cnt_model [NCH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NCH; k++) begin
            q[k].delete();
            cnt_model[k] = 0;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
`ifdef STREAM_DEMUX4_STATS_EN
        check("rst_out_count", out_count, 32'h0);
`endif
    endtask

    // Called between edges after inputs settle: compare, then update the model for the coming edge.
    task automatic evaluate();
        logic [NCH-1:0] exp_vld;
        logic           exp_rdy;
        for (int k = 0; k < NCH; k++) begin
            exp_vld[k] = (q[k].size() != 0);
        end
        check("out_valid", 32'(out_valid), 32'(exp_vld));
        exp_rdy = !exp_vld[in_sel] || out_ready[in_sel];
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef STREAM_DEMUX4_STATS_EN
        for (int k = 0; k < NCH; k++) begin
            check("out_count", 32'(out_count[k*8 +: 8]), 32'(cnt_model[k]));
        end
`endif
        for (int k = 0; k < NCH; k++) begin
            if (exp_vld[k]) begin
                check("out_data", 32'(out_data[k*WIDTH +: WIDTH]), 32'(q[k][0]));
                if (out_ready[k]) begin
                    void'(q[k].pop_front());
                    if (cnt_model[k] < 255) cnt_model[k]++;
                end
            end
        end
        if (in_valid && exp_rdy) begin
            q[in_sel].push_back(in_data);
        end
    endtask

    task automatic cycle(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                         input logic [NCH-1:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        evaluate();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check_reset_outputs();
        clear_model();
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = '0;
        clear_model();
        #1;
        check_reset_outputs();
        for (int s = 0; s < NCH; s++) begin
            in_sel = 2'(s);
            #1;
            check("idle_in_ready", 32'(in_ready), 32'h1);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 2'd0, 8'h00, 4'b0000);

        // Single route with a 5-cycle stall.
        cycle(1'b1, 2'd2, 8'hA5, 4'b0000);
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'd0, 8'h00, 4'b0000);
        check("route_data_held", 32'(out_data[2*WIDTH +: WIDTH]), 32'hA5);
        cycle(1'b0, 2'd0, 8'h00, 4'b0100);
        cycle(1'b0, 2'd0, 8'h00, 4'b0000);

        // Stalled channel 1 must not block channel 3.
        cycle(1'b1, 2'd1, 8'h11, 4'b0000);
        cycle(1'b1, 2'd1, 8'h22, 4'b0000);
        cycle(1'b1, 2'd3, 8'h33, 4'b0000);
        cycle(1'b0, 2'd0, 8'h00, 4'b1010);
        cycle(1'b0, 2'd0, 8'h00, 4'b0000);

        // Back-to-back streaming, including drain-and-reload on the same edge.
        for (int i = 0; i < 8; i++) cycle(1'b1, 2'd0, 8'(i), 4'b1111);
        cycle(1'b0, 2'd0, 8'h00, 4'b1111);
        cycle(1'b0, 2'd0, 8'h00, 4'b1111);

        // Reset mid-flight discards held words.
        cycle(1'b1, 2'd0, 8'hC0, 4'b0000);
        cycle(1'b1, 2'd3, 8'hC3, 4'b0000);
        check("pre_rst_valid", 32'(out_valid), 32'h9);
        pulse_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 8'h00, 4'b1111);
        cycle(1'b1, 2'd1, 8'h5A, 4'b0000);
        cycle(1'b0, 2'd0, 8'h00, 4'b0010);
        cycle(1'b0, 2'd0, 8'h00, 4'b0000);

        // Random traffic on all channels.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 8'h00, 4'b1111);

        // 300 drains on channel 2 from a fresh reset.
        pulse_reset();
        for (int i = 0; i < 300; i++) cycle(1'b1, 2'd2, 8'(i), 4'b1111);
        cycle(1'b0, 2'd0, 8'h00, 4'b1111);
        cycle(1'b0, 2'd0, 8'h00, 4'b1111);
        check("sat_model", 32'(cnt_model[2]), 32'd255);
`ifdef STREAM_DEMUX4_STATS_EN
        check("sat_count", out_count, 32'h00FF_0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux4.md
STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the payload.
REQ-007 The block SHALL have port in_sel, input, 2 bits: the destination channel, 0..3.
REQ-008 The block SHALL have port out_valid, output, 4 bits: the valid bit of each channel.
REQ-009 The block SHALL have port out_ready, input, 4 bits: the downstream ready bit of each channel.
REQ-010 The block SHALL have port out_data, output, 4*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].

Function
REQ-011 Each channel SHALL hold a one-entry slot with two states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-012 in_ready SHALL equal (slot[in_sel] EMPTY) OR out_ready[in_sel], decoded combinationally from in_sel.
REQ-013 An accept occurs when in_valid & in_ready; the slot selected by in_sel loads in_data on that edge and goes FULL.
REQ-014 Accept-to-out_valid latency SHALL be exactly 1 cycle, with no combinational path from in_data to out_data.
REQ-015 A drain occurs on channel k when out_valid[k] & out_ready[k]; the slot goes EMPTY unless it is loaded on the same edge.
REQ-016 A simultaneous drain and load on the same channel SHALL leave the slot FULL with the new word, sustaining 1 word/cycle.
REQ-017 Drains on different channels SHALL be independent and may occur on the same edge; a stalled channel SHALL NOT block accepts for other channels.
REQ-018 While out_valid[k] & ~out_ready[k], out_data[k] SHALL be held stable.
REQ-019 out_data[k] SHALL retain its last value when EMPTY.
REQ-020 in_sel and in_data are don't-care when in_valid=0; no slot changes state in that case except by drain.
REQ-021 Words SHALL be delivered in acceptance order per channel, with no loss and no duplication.

Reset
REQ-022 Asserting rst SHALL immediately force every slot EMPTY, out_valid=4'b0000 and out_data=0, independent of clk.
REQ-023 Words held when rst asserts mid-operation SHALL be discarded; the first clk edge after rst deasserts SHALL accept normally.

Configuration
REQ-024 With macro STREAM_DEMUX4_STATS_EN defined, the block SHALL add output out_count, 4*8 bits: one counter per channel that increments on each drain and saturates at 255.
REQ-025 rst SHALL clear out_count to 0.
REQ-026 Without STREAM_DEMUX4_STATS_EN, the out_count port and its counters SHALL be absent, with identical datapath behaviour.

Structure
REQ-027 Package stream_demux4_pkg SHALL hold NUM_CH=4, the typedef ch_sel_t (2-bit), the typedef slot_state_t (enum EMPTY/FULL) and CNT_W=8.
REQ-028 One sub-module, demux_slot (one-entry register slice with load, drain and valid), SHALL be instantiated four times; the top level holds only the select decode, in_ready mux and optional counters.

Verification
REQ-029 Reset then idle: out_valid=0000, in_ready=1 for all in_sel, and out_count=0 when STATS_EN is defined.
REQ-030 Single route: in_data=8'hA5, in_sel=2, out_ready=0 -> next cycle out_valid=0100 and out_data[2]=A5; the value holds for 5 stalled cycles.
REQ-031 Backpressure: channel 1 FULL with out_ready[1]=0, in_sel=1 -> in_ready=0; switching to in_sel=3 -> in_ready=1 and channel 3 loads.
REQ-032 Streaming: out_ready=1111, eight back-to-back words 8'h00..8'h07 to in_sel=0 -> in_ready is constant 1 and channel 0 emits 00..07 on consecutive cycles, 1 cycle late.
REQ-033 Reset mid-flight: channels 0 and 3 FULL, rst pulsed between edges -> out_valid=0000 immediately, and the words are never emitted.
REQ-034 Saturation (STATS_EN): 300 drains on channel 2 -> out_count[2]=255 while the other counts stay 0.
